// File: rtl/rebote_multicanal_pkg.sv
// Shared definitions for the multi-channel button debouncer: width helper,
// parameter legality check and board-level default timings.
package rebote_multicanal_pkg;

  // Board defaults: 50 MHz clock, 10 ms settle, 500 ms first repeat, 100 ms repeat period.
  localparam int unsigned FRECUENCIA_PLACA_HZ  = 50_000_000;
  localparam int unsigned REBOTE_PLACA_MS      = 10;
  localparam int unsigned CUENTA_ESTABLE_PLACA = (FRECUENCIA_PLACA_HZ / 1000) * REBOTE_PLACA_MS;
  localparam int unsigned RETARDO_REP_PLACA    = CUENTA_ESTABLE_PLACA * 50;
  localparam int unsigned PERIODO_REP_PLACA    = CUENTA_ESTABLE_PLACA * 10;

  function automatic int unsigned clog2_r(input int unsigned valor);
    int unsigned r;
    r = 0;
    for (longint unsigned p = 1; p < longint'(valor); p = p << 1) begin
      r++;
    end
    return r;
  endfunction

  function automatic bit parametros_ok(input int unsigned n_canales,
                                       input int unsigned n_sync,
                                       input int unsigned cuenta_estable,
                                       input int unsigned periodo_rep);
    return (n_canales >= 1) && (n_sync >= 2) && (cuenta_estable >= 1) && (periodo_rep >= 1);
  endfunction

endpackage

// File: rtl/rebote_canal.sv
// One debounce channel: synchroniser, stability counter, debounced level and
// registered rise/fall/auto-repeat pulses.
module rebote_canal
  import rebote_multicanal_pkg::*;
#(
  parameter int unsigned N_SYNC         = 2,
  parameter int unsigned CUENTA_ESTABLE = 16,
  parameter int unsigned RETARDO_REP    = 0,
  parameter int unsigned PERIODO_REP    = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic entrada,
  output logic nivel,
  output logic pulso_sub,
  output logic pulso_baj,
  output logic pulso_rep
);

  localparam int unsigned CNT_W = clog2_r(CUENTA_ESTABLE) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CUENTA_ESTABLE - 1);

  logic [N_SYNC-1:0] sync_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              nivel_q, nivel_d;
  logic              sub_q, sub_d;
  logic              baj_q, baj_d;
  logic              s;
  logic              acepta;

  assign s = sync_q[N_SYNC-1];

  always_comb begin
    cnt_d   = '0;
    nivel_d = nivel_q;
    sub_d   = 1'b0;
    baj_d   = 1'b0;
    acepta  = 1'b0;
    if (s != nivel_q) begin
      if (cnt_q == CNT_MAX) begin
        acepta  = 1'b1;
        nivel_d = s;
        sub_d   = s;
        baj_d   = ~s;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      nivel_q <= 1'b0;
      sub_q   <= 1'b0;
      baj_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[N_SYNC-2:0], entrada};
      cnt_q   <= cnt_d;
      nivel_q <= nivel_d;
      sub_q   <= sub_d;
      baj_q   <= baj_d;
    end
  end

  assign nivel     = nivel_q;
  assign pulso_sub = sub_q;
  assign pulso_baj = baj_q;

  if (RETARDO_REP > 0) begin : g_rep
    localparam int unsigned REP_MAX = (RETARDO_REP > PERIODO_REP) ? RETARDO_REP : PERIODO_REP;
    localparam int unsigned RC_W    = clog2_r(REP_MAX) + 1;

    logic [RC_W-1:0] rc_q, rc_d, rc_inc, meta;
    logic            fase_q, fase_d;
    logic            rep_q, rep_d;

    // fase_q=0 waits for the initial delay, fase_q=1 runs the periodic phase.
    always_comb begin
      rc_d   = '0;
      fase_d = 1'b0;
      rep_d  = 1'b0;
      rc_inc = rc_q + RC_W'(1);
      meta   = fase_q ? RC_W'(PERIODO_REP) : RC_W'(RETARDO_REP);
      // A falling acceptance clears the counter without emitting a repeat.
      if (nivel_q && !acepta) begin
        if (rc_inc == meta) begin
          rep_d  = 1'b1;
          fase_d = 1'b1;
        end else begin
          rc_d   = rc_inc;
          fase_d = fase_q;
        end
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        rc_q   <= '0;
        fase_q <= 1'b0;
        rep_q  <= 1'b0;
      end else begin
        rc_q   <= rc_d;
        fase_q <= fase_d;
        rep_q  <= rep_d;
      end
    end

    assign pulso_rep = rep_q;
  end else begin : g_sin_rep
    assign pulso_rep = 1'b0;
  end

endmodule

// File: rtl/rebote_multicanal.sv
// N-channel button debouncer with edge pulses and optional auto-repeat.
module rebote_multicanal
  import rebote_multicanal_pkg::*;
#(
  parameter int unsigned N_CANALES      = 4,
  parameter int unsigned N_SYNC         = 2,
  parameter int unsigned CUENTA_ESTABLE = 16,
  parameter int unsigned RETARDO_REP    = 0,
  parameter int unsigned PERIODO_REP    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_CANALES-1:0] entrada,
  output logic [N_CANALES-1:0] nivel,
  output logic [N_CANALES-1:0] pulso_sub,
  output logic [N_CANALES-1:0] pulso_baj,
  output logic [N_CANALES-1:0] pulso_rep,
  output logic                 cualquiera
);

  if (!parametros_ok(N_CANALES, N_SYNC, CUENTA_ESTABLE, PERIODO_REP)) begin : g_param_err
    $error("rebote_multicanal: illegal parameter combination");
  end

  for (genvar i = 0; i < N_CANALES; i++) begin : g_canal
    rebote_canal #(
      .N_SYNC        (N_SYNC),
      .CUENTA_ESTABLE(CUENTA_ESTABLE),
      .RETARDO_REP   (RETARDO_REP),
      .PERIODO_REP   (PERIODO_REP)
    ) u_canal (
      .clk      (clk),
      .reset    (reset),
      .entrada  (entrada[i]),
      .nivel    (nivel[i]),
      .pulso_sub(pulso_sub[i]),
      .pulso_baj(pulso_baj[i]),
      .pulso_rep(pulso_rep[i])
    );
  end

  assign cualquiera = |pulso_sub;

endmodule

// File: tb/tb_rebote_multicanal.sv
// Scoreboard bench for rebote_multicanal: stimulus pushes expected pulse
// events (edge number + pulse vectors); a negedge monitor pops and compares.
module tb_rebote_multicanal;

  logic       clk;
  logic       reset;
  logic [3:0] entrada;
  logic [3:0] nivel, pulso_sub, pulso_baj, pulso_rep;
  logic       cualquiera;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  typedef struct {
    int         cyc;
    logic [3:0] sub;
    logic [3:0] baj;
    logic [3:0] rep;
  } ev_t;

  ev_t cola[$];

  rebote_multicanal #(
    .N_CANALES     (4),
    .N_SYNC        (2),
    .CUENTA_ESTABLE(4),
    .RETARDO_REP   (10),
    .PERIODO_REP   (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .entrada   (entrada),
    .nivel     (nivel),
    .pulso_sub (pulso_sub),
    .pulso_baj (pulso_baj),
    .pulso_rep (pulso_rep),
    .cualquiera(cualquiera)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic ev_t mk(input int cyc, input logic [3:0] sub, input logic [3:0] baj,
                             input logic [3:0] rep);
    ev_t e;
    e.cyc = cyc;
    e.sub = sub;
    e.baj = baj;
    e.rep = rep;
    return e;
  endfunction

  // Input on mask rises after edge e and falls after edge e+hold: rise pulse at
  // e+6, repeats at e+16, e+19, ... while high, fall pulse at e+hold+6.
  task automatic push_press(input logic [3:0] mask, input int e, input int hold);
    int t, fin;
    t   = e + 6;
    fin = e + hold + 6;
    cola.push_back(mk(t, mask, 4'b0, 4'b0));
    for (int r = t + 10; r < fin; r += 3) cola.push_back(mk(r, 4'b0, 4'b0, mask));
    cola.push_back(mk(fin, 4'b0, mask, 4'b0));
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_nivel"}, {28'b0, nivel}, 32'h0);
    chk({name, "_pulsos"}, {20'b0, pulso_sub, pulso_baj, pulso_rep}, 32'h0);
    chk({name, "_cualquiera"}, {31'b0, cualquiera}, 32'h0);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      while (cola.size() > 0 && cola[0].cyc < edge_n) begin
        checks++;
        errors++;
        $display("FAIL missing_event: expected at edge %0d sub=%b baj=%b rep=%b, not observed",
                 cola[0].cyc, cola[0].sub, cola[0].baj, cola[0].rep);
        void'(cola.pop_front());
      end
      if ((pulso_sub | pulso_baj | pulso_rep) != 4'b0) begin
        checks++;
        if (cola.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: edge %0d sub=%b baj=%b rep=%b, expected none",
                   edge_n, pulso_sub, pulso_baj, pulso_rep);
        end else begin
          ev_t x;
          x = cola.pop_front();
          if (x.cyc != edge_n || x.sub !== pulso_sub || x.baj !== pulso_baj ||
              x.rep !== pulso_rep || cualquiera !== (x.sub != 4'b0)) begin
            errors++;
            $display("FAIL pulse_event: got edge %0d sub=%b baj=%b rep=%b any=%b, expected edge %0d sub=%b baj=%b rep=%b any=%b",
                     edge_n, pulso_sub, pulso_baj, pulso_rep, cualquiera,
                     x.cyc, x.sub, x.baj, x.rep, x.sub != 4'b0);
          end
        end
      end
    end
  end

  initial begin
    int e, r;
    logic pat [6];
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    reset   = 1'b0;
    entrada = 4'b0;
    repeat (3) @(negedge clk);
    #1 chk_zero("reset_inicial");
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Clean press on channel 0, held 20 cycles.
    e = edge_n;
    entrada[0] = 1'b1;
    push_press(4'b0001, e, 20);
    repeat (5) @(negedge clk);
    #1 chk("press_nivel_antes", {28'b0, nivel}, 32'h0);
    repeat (2) @(negedge clk);
    #1 chk("press_nivel", {28'b0, nivel}, 32'h1);
    repeat (13) @(negedge clk);
    entrada[0] = 1'b0;
    repeat (12) @(negedge clk);
    #1 chk("press_nivel_suelto", {28'b0, nivel}, 32'h0);

    // Glitch of 3 cycles on channel 1: rejected.
    @(negedge clk);
    entrada[1] = 1'b1;
    repeat (3) @(negedge clk);
    entrada[1] = 1'b0;
    repeat (10) @(negedge clk);
    #1 chk("glitch3_nivel", {28'b0, nivel}, 32'h0);

    // Exactly 4 cycles on channel 1: accepted, then released.
    @(negedge clk);
    e = edge_n;
    entrada[1] = 1'b1;
    push_press(4'b0010, e, 4);
    repeat (4) @(negedge clk);
    entrada[1] = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk("glitch4_nivel", {28'b0, nivel}, 32'h2);
    repeat (8) @(negedge clk);
    #1 chk("glitch4_nivel_suelto", {28'b0, nivel}, 32'h0);

    // Bounce on channel 2; the stable run starts with the drive after edge e+5.
    @(negedge clk);
    e = edge_n;
    push_press(4'b0100, e + 5, 8);
    for (int i = 0; i < 6; i++) begin
      entrada[2] = pat[i];
      @(negedge clk);
    end
    repeat (7) @(negedge clk);
    entrada[2] = 1'b0;
    repeat (10) @(negedge clk);
    #1 chk("rebote_nivel", {28'b0, nivel}, 32'h0);

    // Auto-repeat on channel 3: held 40 cycles past the rise pulse.
    @(negedge clk);
    e = edge_n;
    entrada[3] = 1'b1;
    push_press(4'b1000, e, 46);
    repeat (20) @(negedge clk);
    #1 chk("rep_nivel", {28'b0, nivel}, 32'h8);
    repeat (26) @(negedge clk);
    entrada[3] = 1'b0;
    repeat (12) @(negedge clk);

    // Channels 0 and 2 together.
    e = edge_n;
    entrada = 4'b0101;
    push_press(4'b0101, e, 5);
    repeat (5) @(negedge clk);
    entrada = 4'b0000;
    repeat (12) @(negedge clk);

    // Reset while the stability counter is at 2.
    e = edge_n;
    entrada[0] = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1 chk_zero("reset_cnt2");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    r = edge_n;
    cola.push_back(mk(r + 6, 4'b0001, 4'b0, 4'b0));
    repeat (11) @(negedge clk);
    #1 chk("hold_nivel", {28'b0, nivel}, 32'h1);
    // Repeat counter is at 5 here; reset must clear everything at once.
    reset = 1'b0;
    #1 chk_zero("reset_rc5");
    @(negedge clk);
    #1 chk_zero("reset_rc5_mantenido");
    @(negedge clk);
    reset = 1'b1;
    e = edge_n;
    push_press(4'b0001, e, 12);
    repeat (12) @(negedge clk);
    entrada[0] = 1'b0;
    repeat (20) @(negedge clk);
    #1 chk_zero("final");

    chk("cola_vacia", cola.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rebote_multicanal.md
Name: rebote_multicanal

Overview:
- N-channel debounce and edge-detect block for mechanical push-buttons and switches.
- Each channel: synchroniser, stability counter, debounced level, one-cycle rising and falling pulses, optional auto-repeat pulse while held.
- Sits between board button pins and the control FSMs; replaces single-channel shift-register edge detectors.

Parameters:
- N_CANALES, 4, number of independent channels (>=1)
- N_SYNC, 2, synchroniser flop stages per channel (>=2)
- CUENTA_ESTABLE, 16, consecutive cycles the synchronised input must differ from `nivel` before it is accepted (>=1)
- RETARDO_REP, 0, cycles from rising acceptance to first repeat pulse; 0 disables auto-repeat
- PERIODO_REP, 1, cycles between subsequent repeat pulses (>=1, ignored when RETARDO_REP=0)

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- entrada  input  N_CANALES  raw asynchronous button inputs, bit i = channel i
- nivel  output  N_CANALES  debounced level per channel
- pulso_sub  output  N_CANALES  one-cycle pulse on accepted 0->1
- pulso_baj  output  N_CANALES  one-cycle pulse on accepted 1->0
- pulso_rep  output  N_CANALES  one-cycle auto-repeat pulse while held high
- cualquiera  output  1  OR of all pulso_sub bits

Behaviour:
- Reset (reset=0, async): all synchroniser flops, counters, nivel, and pulse registers go to 0 immediately. Reset mid-operation aborts pending acceptances and repeats without emitting pulses.
- Outputs are registered; `cualquiera` is a combinational OR of the registered pulso_sub bits.
- Synchroniser: N_SYNC-stage shift per channel; `s` = last stage.
- Stability counter `cnt`, width clog2(CUENTA_ESTABLE)+1. On each edge:
  - s==nivel: cnt<=0.
  - s!=nivel and cnt<CUENTA_ESTABLE-1: cnt<=cnt+1.
  - s!=nivel and cnt==CUENTA_ESTABLE-1: nivel<=s, cnt<=0, and the matching pulso_sub or pulso_baj bit is high for exactly the following cycle.
- Latency: let edge 1 be the first rising edge sampling the new input value. nivel and the pulse update at edge N_SYNC+CUENTA_ESTABLE, provided the input stayed constant throughout.
- Glitch rejection: a deviation shorter than CUENTA_ESTABLE synchronised cycles never changes nivel. Exactly CUENTA_ESTABLE cycles is accepted. Any return to nivel restarts the count from 0.
- Auto-repeat (RETARDO_REP>0):
  - Per-channel counter `rc` is cleared on the pulso_sub edge and increments each edge while nivel=1.
  - pulso_rep fires at RETARDO_REP edges after the pulso_sub edge, then every PERIODO_REP edges after that, for as long as nivel=1.
  - `rc` saturates/wraps internally so repeats continue indefinitely.
- When nivel falls, `rc` clears and no pulso_rep is issued in that cycle or later.
- pulso_rep never coincides with pulso_sub.
- RETARDO_REP=0: pulso_rep is constant 0 and no repeat counter is synthesised.
- Channels are fully independent; simultaneous events on several channels each produce their own pulses in the same cycle.
- Input high at reset release: treated as a normal 0->1 change. pulso_sub fires at edge N_SYNC+CUENTA_ESTABLE after release.

Decomposition:
- Shared package holds:
  - the clog2 helper function;
  - the parameter legality checks (N_SYNC>=2, CUENTA_ESTABLE>=1, PERIODO_REP>=1);
  - the default constants for the button debounce time at board clock.
- Sub-module `rebote_canal`: one channel (synchroniser, stability counter, repeat counter, three pulse registers). Top is a generate loop over N_CANALES plus the `cualquiera` OR.

Test Plan:
All scenarios use N_CANALES=4, N_SYNC=2, CUENTA_ESTABLE=4, RETARDO_REP=10, PERIODO_REP=3.
- Clean press: entrada[0] 0->1 before edge 1, held 20 cycles -> nivel[0]=1 and pulso_sub[0]=1 after edge 6; pulso_sub[0] low after edge 7; cualquiera mirrors pulso_sub[0]; other channels stay 0.
- Glitch: entrada[1] high for 3 cycles then low -> nivel[1], pulso_sub[1], pulso_baj[1] stay 0 throughout. Repeat with 4 cycles high -> nivel[1]=1 after edge 6, then pulso_baj[1] 4 cycles after the falling input's own edge 6.
- Bounce: entrada[2] toggles 1,0,1,1,0,1, then holds 1 -> exactly one pulso_sub[2]; cnt restarts on every return to 0.
- Auto-repeat: hold entrada[3] high 40 cycles from edge T=pulso_sub edge -> pulso_rep[3] at T+10, T+13, T+16, ...; release -> pulso_baj[3] once and no further pulso_rep.
- Simultaneous: entrada[0] and entrada[2] rise on the same edge -> pulso_sub=4'b0101 in one cycle, cualquiera=1 for one cycle.
- Reset mid-operation: assert reset at cnt=2 during a press and at rc=5 during a hold -> all outputs 0 asynchronously, no pulses. After release with entrada still high -> pulso_sub after edge 6.
